// File: rtl/adder_sched_pkg.sv
// Shared op codes, FSM state encoding and flag bit positions for adder_sched.
package adder_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_INC = 2'b11;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_O = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_sched_rr2.sv
// Two-way round-robin grant; last_grant advances only when a grant is taken.
module adder_sched_rr2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = '0;
        if (i_en) begin
            unique case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
                default: o_grant = '0;
            endcase
        end
    end

    // A grant with i_en high is always accepted by the sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (|o_grant) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/unit_A.sv
// Shared 32-bit ripple add/subtract unit: a+b, a-b, -b, b+1 with carry-out
// and signed overflow.
module unit_A
    import adder_sched_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  f,
    output logic [31:0] s,
    output logic        c_out,
    output logic        O
);

    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic [32:0] w_sum;

    // Every op is x + y + cin; subtraction/negation use the inverted-b form.
    always_comb begin
        w_x   = a;
        w_y   = b;
        w_cin = 1'b0;
        unique case (f)
            OP_ADD: w_cin = 1'b0;
            OP_SUB: begin w_y = ~b; w_cin = 1'b1; end
            OP_NEG: begin w_x = '0; w_y = ~b; w_cin = 1'b1; end
            OP_INC: begin w_x = b;  w_y = '0; w_cin = 1'b1; end
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + 33'(w_cin);
    assign s     = w_sum[31:0];
    assign c_out = w_sum[32];
    assign O     = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);

endmodule

// File: rtl/adder_sched.sv
// Two-requester sequencer for unit_A with settle timer and one-entry response
// buffer. Optional sticky overflow flag: define ADDER_SCHED_STICKY_OVF_EN.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_f,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_f,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_s,
    output logic [3:0]  rsp_flags
`ifdef ADDER_SCHED_STICKY_OVF_EN
    ,
    input  logic        ovf_clr,
    output logic        ovf_sticky
`endif
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_f;
    logic        r_id;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_s;
    logic [3:0]  r_rsp_flags;

    logic [1:0]  w_grant;
    logic [31:0] w_s;
    logic        w_c;
    logic        w_o;
    logic [3:0]  w_flags;

    adder_sched_rr2 u_rr2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (r_state == IDLE),
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );

    unit_A u_unit_A (
        .a     (r_a),
        .b     (r_b),
        .f     (r_f),
        .s     (w_s),
        .c_out (w_c),
        .O     (w_o)
    );

    always_comb begin
        w_flags        = '0;
        w_flags[FLG_N] = w_s[31];
        w_flags[FLG_Z] = (w_s == '0);
        w_flags[FLG_C] = w_c;
        w_flags[FLG_O] = w_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_f         <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_flags <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_a     <= w_grant[1] ? req1_a : req0_a;
                        r_b     <= w_grant[1] ? req1_b : req0_b;
                        r_f     <= w_grant[1] ? req1_f : req0_f;
                        r_id    <= w_grant[1];
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_rsp_s     <= w_s;
                        r_rsp_flags <= w_flags;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_s      = r_rsp_s;
    assign rsp_flags  = r_rsp_flags;

`ifdef ADDER_SCHED_STICKY_OVF_EN
    logic r_ovf_sticky;
    logic w_capture;

    assign w_capture = (r_state == BUSY) && (r_cnt == CNT_LAST);

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_capture && w_o) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Directed self-checking bench for adder_sched (SETTLE_CYCLES = 4).
module tb_adder_sched;

    localparam int unsigned SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_f, req1_f;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_s;
    logic [3:0]  rsp_flags;
`ifdef ADDER_SCHED_STICKY_OVF_EN
    logic        ovf_clr;
    logic        ovf_sticky;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    adder_sched #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_flags  (rsp_flags)
`ifdef ADDER_SCHED_STICKY_OVF_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] f, output logic [31:0] s,
                          output logic [3:0] fl, output logic rid, output int lat);
        bit got;
        @(negedge clk);
        if (id) begin req1_a = a; req1_b = b; req1_f = f; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_f = f; req0_valid = 1'b1; end
        got = 0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin got = 1; break; end
            @(negedge clk);
        end
        check_eq("accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) begin got = 1; break; end
        end
        check_eq("rsp_seen", 32'(got), 32'd1);
        s   = rsp_s;
        fl  = rsp_flags;
        rid = rsp_id;
        @(posedge clk);
        #1;
        check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] s;
    logic [3:0]  fl;
    logic        rid;
    int          lat;
    bit          seen;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_f = '0;
        req1_a = '0; req1_b = '0; req1_f = '0;
        rsp_ready = 1'b1;
`ifdef ADDER_SCHED_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_s", rsp_s, 32'd0);
        check_eq("rst_flags", 32'(rsp_flags), 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        check_eq("rst_ready0", 32'(req0_ready), 32'd0);
`ifdef ADDER_SCHED_STICKY_OVF_EN
        check_eq("rst_sticky", 32'(ovf_sticky), 32'd0);
`endif

        run_op(1'b0, 32'd5, 32'd7, 2'b00, s, fl, rid, lat);
        check_eq("add_s", s, 32'd12);
        check_eq("add_flags", 32'(fl), 32'h0);
        check_eq("add_id", 32'(rid), 32'd0);
        check_eq("add_latency", 32'(lat), 32'(SETTLE));

        run_op(1'b1, 32'd3, 32'd3, 2'b01, s, fl, rid, lat);
        check_eq("sub_s", s, 32'd0);
        check_eq("sub_flags", 32'(fl), 32'h6);
        check_eq("sub_id", 32'(rid), 32'd1);

        run_op(1'b1, 32'd0, 32'd1, 2'b10, s, fl, rid, lat);
        check_eq("neg_s", s, 32'hFFFF_FFFF);
        check_eq("neg_flags", 32'(fl), 32'h8);

        run_op(1'b0, 32'd0, 32'hFFFF_FFFF, 2'b11, s, fl, rid, lat);
        check_eq("inc_wrap_s", s, 32'd0);
        check_eq("inc_wrap_flags", 32'(fl), 32'h6);

        run_op(1'b0, 32'h7FFF_FFFF, 32'd1, 2'b00, s, fl, rid, lat);
        check_eq("ovf_s", s, 32'h8000_0000);
        check_eq("ovf_flags", 32'(fl), 32'h9);
`ifdef ADDER_SCHED_STICKY_OVF_EN
        repeat (3) @(posedge clk);
        #1 check_eq("sticky_hold", 32'(ovf_sticky), 32'd1);
        @(negedge clk) ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        check_eq("sticky_clr", 32'(ovf_sticky), 32'd0);
`endif

        // Back-pressure: response must hold and both requesters stay blocked.
        rsp_ready = 1'b0;
        @(negedge clk);
        req0_a = 32'd100; req0_b = 32'd50; req0_f = 2'b01; req0_valid = 1'b1;
        #1 check_eq("stall_accept", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin seen = 1; break; end
        end
        check_eq("stall_rsp_seen", 32'(seen), 32'd1);
        req0_a = 32'd1; req0_b = 32'd1; req0_f = 2'b00; req0_valid = 1'b1;
        req1_a = 32'd2; req1_b = 32'd2; req1_f = 2'b00; req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq("stall_valid", 32'(rsp_valid), 32'd1);
            check_eq("stall_s", rsp_s, 32'd50);
            check_eq("stall_flags", 32'(rsp_flags), 32'h2);
            check_eq("stall_id", 32'(rsp_id), 32'd0);
            check_eq("stall_ready0", 32'(req0_ready), 32'd0);
            check_eq("stall_ready1", 32'(req1_ready), 32'd0);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1 check_eq("stall_release", 32'(rsp_valid), 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 if (rsp_valid) seen = 1;
        end
        check_eq("stall_no_extra", 32'(seen), 32'd0);

        // Reset mid-BUSY after a requester-0 accept, so tie must return to 0.
        @(negedge clk);
        req0_a = 32'd1; req0_b = 32'd1; req0_f = 2'b00; req0_valid = 1'b1;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst2_s", rsp_s, 32'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 if (rsp_valid) seen = 1;
        end
        check_eq("rst2_no_rsp", 32'(seen), 32'd0);

        @(negedge clk);
        req0_a = 32'd10; req0_b = 32'd1; req0_f = 2'b00; req0_valid = 1'b1;
        req1_a = 32'd20; req1_b = 32'd2; req1_f = 2'b01; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                if (rsp_valid) begin seen = 1; break; end
            end
            check_eq("rr_rsp_seen", 32'(seen), 32'd1);
            check_eq("rr_id", 32'(rsp_id), 32'(i % 2));
            check_eq("rr_s", rsp_s, (i % 2 == 1) ? 32'd18 : 32'd11);
            check_eq("rr_blocked", 32'({req1_ready, req0_ready}), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_sched.md
# adder_sched

Sequencer and two-requester arbiter for the shared 32-bit add/subtract unit `unit_A`.
- Accepts operations from two requesters over valid/ready and grants them round-robin.
- Drives `unit_A` from registered operands and waits a programmable settle time for the ripple carry chain.
- Captures sum and N/Z/C/O flags into a one-entry response buffer that is drained over valid/ready.

## Interface
- `SETTLE_CYCLES`, default 4: cycles operands are held on `unit_A` before capture; legal range 1..15.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` input, 1 each: requester has an operation.
- `req0_ready`, `req1_ready` output, 1 each: operation accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` input, 32 each: operands.
- `req0_f`, `req1_f` input, 2 each: op code. 00 = a+b, 01 = a−b, 10 = −b, 11 = b+1.
- `rsp_valid` output, 1: response held.
- `rsp_ready` input, 1: consumer takes the response.
- `rsp_id` output, 1: requester that issued the response.
- `rsp_s` output, 32: result.
- `rsp_flags` output, 4: {N,Z,C,O}.
- `ovf_sticky` output, 1: present only with `ADDER_SCHED_STICKY_OVF_EN`.
- `ovf_clr` input, 1: present only with `ADDER_SCHED_STICKY_OVF_EN`.

## Operation
- States:
  - IDLE: `req*_ready` may assert; transitions to BUSY on accept.
  - BUSY: counter `cnt` runs 0..SETTLE_CYCLES−1. At `cnt == SETTLE_CYCLES−1`, `unit_A` outputs are captured into the response registers and the state moves to RESP.
  - RESP: `rsp_valid` = 1. On `rsp_valid && rsp_ready` the state moves to IDLE.
- Arbitration, evaluated in IDLE only:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` = IDLE && granted N. It is combinational from `req*_valid`; a requester must not make `valid` depend on `ready`.
- On accept, a, b, f and id are registered. `unit_A` inputs come only from these registers and never from the request ports.
- Flags:
  - N = s[31].
  - Z = (s == 0), computed in this block.
  - C = `unit_A` c_out.
  - O = `unit_A` O.
- Requests arriving in BUSY or RESP are held off (ready = 0); no queueing beyond the single in-flight operation.
- While `rsp_valid && !rsp_ready`, `rsp_s`, `rsp_flags` and `rsp_id` are stable.
- Reset values:
  - state IDLE, `cnt` 0, `last_grant` 1.
  - `rsp_valid` 0, `rsp_id` 0, `rsp_s` 0, `rsp_flags` 0.
  - operand registers 0, `ovf_sticky` 0.
- Reset mid-BUSY or mid-RESP discards the operation; no response is ever produced for it.

## Timing
- Accept happens on edge T, i.e. the cycle with `reqN_valid && reqN_ready`.
- `rsp_valid` rises after edge T+SETTLE_CYCLES.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle.
- The next accept is possible in the cycle after the response handshake. Minimum issue interval is SETTLE_CYCLES+2 cycles.
- SETTLE_CYCLES × clock period must exceed the worst-case `unit_A` propagation; for default timing use ≥ 20 ns total.

## Configuration
- Macro: `ADDER_SCHED_STICKY_OVF_EN`.
- Defined:
  - `ovf_sticky` sets on the cycle the response is captured with O = 1.
  - It clears on `ovf_clr`. If set and clear happen in the same cycle, set wins.
  - It resets to 0.
- Undefined: `ovf_sticky` and `ovf_clr` ports and their logic are absent; all other behaviour is identical.

## Structure
- Package `adder_sched_pkg` holds:
  - op code localparams `OP_ADD`, `OP_SUB`, `OP_NEG`, `OP_INC`.
  - state encoding IDLE/BUSY/RESP.
  - flag bit indices `FLG_N`=3, `FLG_Z`=2, `FLG_C`=1, `FLG_O`=0.
- Sub-module `adder_sched_rr2`: two-way round-robin grant with a `last_grant` register. It updates only on accept.
- The existing `unit_A` is instantiated unchanged as the datapath.

## Test plan
- req0: a=5, b=7, f=00 → `rsp_s`=12, flags 0000, `rsp_id`=0; `rsp_valid` rises exactly SETTLE_CYCLES edges after accept.
- req1: a=3, b=3, f=01 → `rsp_s`=0, flags Z=1, C=1 (0110); then f=10, b=1 → `rsp_s`=0xFFFFFFFF, N=1.
- a=0x7FFFFFFF, b=1, f=00 → `rsp_s`=0x80000000, flags N=1, O=1 (1001); with the macro, `ovf_sticky`=1 until `ovf_clr`.
- Both requesters valid continuously → grants alternate 0,1,0,1 starting with 0; each `rsp_id` matches its issuer.
- `rsp_ready` low for 5 cycles → `rsp_s`/flags/id stable, both `req*_ready` 0, no new accept until after the handshake.
- `rst` pulsed during BUSY → no `rsp_valid`; next op after reset grants requester 0 first and completes normally.
